// File: rtl/word_deserializer.sv
// word_deserializer: rebuilds 12-bit words from a 1-bit serial stream framed by
// a new_word strobe. Optional stride-based bit descrambling, a one-entry output
// buffer with ready/valid handshake, a sticky overrun flag and a saturating
// count of truncated (resynchronised) words.
module word_deserializer #(
   parameter int unsigned PERM_STEP = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ser_in,
   input  logic        new_word,
   input  logic        scr_en,
   input  logic        word_ready,
   input  logic        clr,
   output logic [11:0] word_out,
   output logic        word_valid,
   output logic        overrun,
   output logic [7:0]  frame_err_cnt
);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic        r_scr, w_scr_nxt;
   logic [11:0] r_acc, w_acc_nxt;
   logic [11:0] r_word_out;
   logic        r_word_valid;
   logic        r_overrun;
   logic [7:0]  r_frame_err_cnt;

   logic        w_start;
   logic        w_resync;
   logic        w_capture;
   logic        w_done;
   logic [3:0]  w_pos;
   logic        w_pos_scr;
   logic [3:0]  w_bit_idx;

   // Word bit loaded by a serial position: identity, or (PERM_STEP*pos) mod 12.
   function automatic logic [3:0] f_map(input logic [3:0] pos, input logic scr);
      int unsigned v;
      if (scr) begin
         v = (PERM_STEP * 32'(pos)) % 12;
         return 4'(v);
      end
      return pos;
   endfunction

   // State, bit counter, latched scramble mode and partial word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_scr   <= 1'b0;
         r_acc   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_scr   <= w_scr_nxt;
         r_acc   <= w_acc_nxt;
      end
   end

   // Next-state logic: framing, position tracking and bit placement.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_scr_nxt   = r_scr;
      w_acc_nxt   = r_acc;
      w_start     = 1'b0;
      w_resync    = 1'b0;
      w_capture   = 1'b0;
      w_done      = 1'b0;
      w_pos       = r_cnt;
      w_pos_scr   = r_scr;

      case (r_state)
         IDLE: begin
            if (new_word) begin
               w_start = 1'b1;
            end
         end
         COLLECT: begin
            if (new_word) begin
               // Strobe inside a word: drop the partial word and restart at position 0.
               w_resync = 1'b1;
            end else begin
               w_capture = 1'b1;
               if (r_cnt == 4'd11) begin
                  w_done      = 1'b1;
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 4'd1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      if (w_start || w_resync) begin
         w_pos       = '0;
         w_pos_scr   = scr_en;
         w_scr_nxt   = scr_en;
         w_cnt_nxt   = 4'd1;
         w_state_nxt = COLLECT;
         w_acc_nxt   = '0;
      end

      w_bit_idx = f_map(w_pos, w_pos_scr);
      if (w_start || w_resync || w_capture) begin
         for (int unsigned i = 0; i < 12; i++) begin
            if (w_bit_idx == 4'(i)) begin
               w_acc_nxt[i] = ser_in;
            end
         end
      end
   end

   // One-entry output buffer: load on completion when free or being drained.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_word_out   <= '0;
         r_word_valid <= 1'b0;
      end else if (w_done && (!r_word_valid || word_ready)) begin
         r_word_out   <= w_acc_nxt;
         r_word_valid <= 1'b1;
      end else if (r_word_valid && word_ready) begin
         r_word_valid <= 1'b0;
      end
   end

   // Sticky overrun and saturating frame error count; clr overrides events.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overrun       <= 1'b0;
         r_frame_err_cnt <= '0;
      end else if (clr) begin
         r_overrun       <= 1'b0;
         r_frame_err_cnt <= '0;
      end else begin
         if (w_done && r_word_valid && !word_ready) begin
            r_overrun <= 1'b1;
         end
         if (w_resync && (r_frame_err_cnt != 8'hFF)) begin
            r_frame_err_cnt <= r_frame_err_cnt + 8'd1;
         end
      end
   end

   assign word_out      = r_word_out;
   assign word_valid    = r_word_valid;
   assign overrun       = r_overrun;
   assign frame_err_cnt = r_frame_err_cnt;

endmodule

// File: tb/tb_word_deserializer.sv
// Directed bench for word_deserializer: in-order, scrambled, back-to-back,
// resync, saturation, backpressure/overrun, replace-on-ready and reset cases.
module tb_word_deserializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ser_in = 1'b0;
   logic        new_word = 1'b0;
   logic        scr_en = 1'b0;
   logic        word_ready = 1'b0;
   logic        clr = 1'b0;
   logic [11:0] word_out;
   logic        word_valid;
   logic        overrun;
   logic [7:0]  frame_err_cnt;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Serial position k carries this word bit in scrambled mode (stride 7).
   int unsigned perm [12] = '{0, 7, 2, 9, 4, 11, 6, 1, 8, 3, 10, 5};

   word_deserializer #(.PERM_STEP(7)) dut (
      .clk           (clk),
      .rst           (rst),
      .ser_in        (ser_in),
      .new_word      (new_word),
      .scr_en        (scr_en),
      .word_ready    (word_ready),
      .clr           (clr),
      .word_out      (word_out),
      .word_valid    (word_valid),
      .overrun       (overrun),
      .frame_err_cnt (frame_err_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) step();
   endtask

   // Drive serial positions first..first+n-1 of word w; strobe on position 0.
   // scr_en is inverted after the strobe to show it is only sampled at the start.
   task automatic send(input logic [11:0] w, input logic scr,
                       input int unsigned first, input int unsigned n);
      for (int unsigned k = first; k < first + n; k++) begin
         new_word = (k == 0);
         scr_en   = (k == 0) ? scr : ~scr;
         ser_in   = scr ? w[perm[k]] : w[k];
         step();
      end
      new_word = 1'b0;
      ser_in   = 1'b0;
   endtask

   initial begin
      // Asynchronous reset with no clock edge involved
      #1 rst = 1'b0;
      #1;
      chk("rst_word_out", 32'(word_out), 32'h000);
      chk("rst_valid", 32'(word_valid), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      chk("rst_ferr", 32'(frame_err_cnt), 32'h00);
      idle(2);
      rst = 1'b1;

      // Serial data without a strobe is ignored
      ser_in = 1'b1;
      idle(14);
      ser_in = 1'b0;
      chk("nostrobe_valid", 32'(word_valid), 32'h0);

      // In-order word, valid for exactly one cycle
      word_ready = 1'b1;
      send(12'hA5C, 1'b0, 0, 12);
      chk("inorder_valid", 32'(word_valid), 32'h1);
      chk("inorder_word", 32'(word_out), 32'hA5C);
      idle(1);
      chk("inorder_valid_drop", 32'(word_valid), 32'h0);

      // Scrambled word
      send(12'h3C1, 1'b1, 0, 12);
      chk("scr_valid", 32'(word_valid), 32'h1);
      chk("scr_word", 32'(word_out), 32'h3C1);
      idle(1);

      // Back-to-back words, zero gap
      send(12'h001, 1'b0, 0, 12);
      chk("b2b_first", 32'(word_out), 32'h001);
      chk("b2b_first_valid", 32'(word_valid), 32'h1);
      send(12'hFFE, 1'b0, 0, 1);
      chk("b2b_gap_valid", 32'(word_valid), 32'h0);
      send(12'hFFE, 1'b0, 1, 11);
      chk("b2b_second", 32'(word_out), 32'hFFE);
      chk("b2b_second_valid", 32'(word_valid), 32'h1);
      chk("b2b_ferr", 32'(frame_err_cnt), 32'h00);
      idle(1);

      // Resync at position 5
      send(12'hFFF, 1'b0, 0, 5);
      chk("resync_no_partial", 32'(word_valid), 32'h0);
      send(12'h555, 1'b0, 0, 12);
      chk("resync_word", 32'(word_out), 32'h555);
      chk("resync_ferr", 32'(frame_err_cnt), 32'h01);
      idle(1);
      chk("resync_single", 32'(word_valid), 32'h0);

      // Frame error counter saturation, then clr winning over a resync
      scr_en = 1'b0;
      ser_in = 1'b0;
      new_word = 1'b1;
      idle(260);
      chk("sat_ferr", 32'(frame_err_cnt), 32'hFF);
      clr = 1'b1;
      step();
      clr = 1'b0;
      new_word = 1'b0;
      chk("clr_wins_ferr", 32'(frame_err_cnt), 32'h00);
      ser_in = 1'b1;
      idle(11);
      ser_in = 1'b0;
      chk("after_clr_word", 32'(word_out), 32'hFFE);
      chk("after_clr_valid", 32'(word_valid), 32'h1);
      chk("after_clr_ferr", 32'(frame_err_cnt), 32'h00);
      idle(1);

      // Backpressure: second word dropped, overrun set, clr clears it
      word_ready = 1'b0;
      send(12'h111, 1'b0, 0, 12);
      chk("bp_first", 32'(word_out), 32'h111);
      send(12'h222, 1'b0, 0, 12);
      chk("bp_hold_word", 32'(word_out), 32'h111);
      chk("bp_hold_valid", 32'(word_valid), 32'h1);
      chk("bp_overrun", 32'(overrun), 32'h1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("bp_clr_overrun", 32'(overrun), 32'h0);
      chk("bp_clr_valid", 32'(word_valid), 32'h1);
      word_ready = 1'b1;
      step();
      chk("bp_drain_valid", 32'(word_valid), 32'h0);

      // Completion on a full buffer while ready: replace, no overrun
      word_ready = 1'b0;
      send(12'h123, 1'b0, 0, 12);
      send(12'h456, 1'b0, 0, 11);
      chk("repl_hold", 32'(word_out), 32'h123);
      word_ready = 1'b1;
      send(12'h456, 1'b0, 11, 1);
      chk("repl_word", 32'(word_out), 32'h456);
      chk("repl_valid", 32'(word_valid), 32'h1);
      chk("repl_overrun", 32'(overrun), 32'h0);

      // Reset at position 6 with a buffered word and a nonzero error count
      word_ready = 1'b0;
      send(12'hABC, 1'b0, 0, 3);
      send(12'hABC, 1'b0, 0, 6);
      chk("pre_rst_ferr", 32'(frame_err_cnt), 32'h01);
      chk("pre_rst_valid", 32'(word_valid), 32'h1);
      rst = 1'b0;
      #1;
      chk("midrst_word", 32'(word_out), 32'h000);
      chk("midrst_valid", 32'(word_valid), 32'h0);
      chk("midrst_overrun", 32'(overrun), 32'h0);
      chk("midrst_ferr", 32'(frame_err_cnt), 32'h00);
      idle(2);
      rst = 1'b1;
      word_ready = 1'b1;
      send(12'h5A3, 1'b0, 0, 12);
      chk("postrst_word", 32'(word_out), 32'h5A3);
      chk("postrst_valid", 32'(word_valid), 32'h1);
      chk("postrst_ferr", 32'(frame_err_cnt), 32'h00);
      idle(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/word_deserializer.md
WORD_DESERIALIZER -- requirements
Module: word_deserializer

Interface
REQ-001 Parameter: PERM_STEP, default 7, descramble stride; SHALL be coprime to 12.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset.
REQ-004 Port: ser_in  input  1  serial data bit from the upstream serializer, one bit per clk.
REQ-005 Port: new_word  input  1  upstream strobe; high in the same cycle as bit 0 of a word on ser_in.
REQ-006 Port: scr_en  input  1  1 = scrambled stream, 0 = in-order stream; sampled only on a new_word cycle.
REQ-007 Port: word_ready  input  1  downstream accepts word_out when high together with word_valid.
REQ-008 Port: clr  input  1  synchronous clear of overrun and frame_err_cnt.
REQ-009 Port: word_out  output  12  reassembled, descrambled word.
REQ-010 Port: word_valid  output  1  word_out holds an unaccepted word.
REQ-011 Port: overrun  output  1  sticky; a completed word was dropped.
REQ-012 Port: frame_err_cnt  output  8  saturating count of truncated words.

Function
REQ-013 Serial position k (0..11) SHALL be the k-th bit after, and including, the new_word cycle.
REQ-014 In-order mode: position k SHALL load word bit k (LSB first).
REQ-015 Scrambled mode: position k SHALL load word bit (PERM_STEP*k) mod 12; default map 0,7,2,9,4,11,6,1,8,3,10,5.
REQ-016 FSM states: IDLE, COLLECT; bit counter 4 bits, range 0..11.
REQ-017 IDLE: new_word=1 SHALL capture position 0, latch scr_en, set counter to 1, go to COLLECT; ser_in ignored otherwise.
REQ-018 COLLECT, new_word=0: capture position = counter, then increment counter.
REQ-019 COLLECT, capture of position 11: the word is complete; go to IDLE.
REQ-020 Completion and a new_word on the following cycle SHALL be lossless (back-to-back words, zero gap).
REQ-021 COLLECT, new_word=1 with counter 1..11: discard partial word, increment frame_err_cnt, treat the cycle as position 0 of a new word.
REQ-022 frame_err_cnt SHALL saturate at 255.
REQ-023 Output buffer is one entry; a completed word SHALL appear on word_out with word_valid=1 in the cycle after position 11 is sampled (latency 1 clk).
REQ-024 word_valid && word_ready SHALL empty the buffer at that edge; word_out is held stable while word_valid=1 and word_ready=0.
REQ-025 Completion while the buffer is full and word_ready=0: drop the new word, keep the buffered word, set overrun.
REQ-026 Completion while the buffer is full and word_ready=1: accept the old word and load the new one; word_valid stays 1, no overrun.
REQ-027 clr=1 SHALL zero overrun and frame_err_cnt; an event in the same cycle SHALL be ignored (clr wins).
REQ-028 scr_en changes during COLLECT SHALL NOT affect the word in progress.

Reset
REQ-029 rst=0 SHALL asynchronously force: IDLE, counter 0, word_out 12'h000, word_valid 0, overrun 0, frame_err_cnt 0.
REQ-030 Reset asserted mid-word SHALL discard the partial word without counting a frame error.
REQ-031 First word after rst release SHALL require a new_word strobe.

Verification
REQ-032 In-order: scr_en=0, word_ready=1, 12'hA5C sent LSB-first from new_word -> word_out=12'hA5C, word_valid high exactly 1 clk, at the cycle after bit 11.
REQ-033 Scrambled: scr_en=1, send serial bits = word[0,7,2,9,4,11,6,1,8,3,10,5] of 12'h3C1 -> word_out=12'h3C1.
REQ-034 Back-to-back: 12'h001, 12'hFFE with zero gap, word_ready=1 -> two valid pulses 12 clk apart, correct values, frame_err_cnt=0.
REQ-035 Resync: new_word re-asserted at position 5, then a full 12'h555 -> frame_err_cnt=1, only 12'h555 delivered.
REQ-036 Backpressure: word_ready=0, 12'h111 then 12'h222 -> word_out stays 12'h111, overrun=1; clr -> overrun=0.
REQ-037 Reset: rst=0 at position 6 -> all outputs 0 immediately; the next full word after release is delivered correctly.
